// File: rtl/and_or_pkg.sv
// Shared types, defaults and the AND-OR reduction used by and_or_pipe and its bench model.
package and_or_pkg;

    localparam int unsigned COUNT_W_DEF = 8;
    localparam int unsigned VEC_MAX     = 256;

    typedef logic [VEC_MAX-1:0] and_or_vec_t;

    // Lane w of the result is the OR over pairs p of a[p*width+w] & b[p*width+w].
    function automatic and_or_vec_t and_or_reduce(input and_or_vec_t a,
                                                  input and_or_vec_t b,
                                                  input int unsigned num_pairs,
                                                  input int unsigned width);
        and_or_vec_t r;
        logic [7:0]  idx;
        r = '0;
        for (int unsigned p = 0; p < num_pairs; p++) begin
            for (int unsigned w = 0; w < width; w++) begin
                idx = 8'(p * width + w);
                r[8'(w)] = r[8'(w)] | (a[idx] & b[idx]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/and_or_stage.sv
// One valid/ready pipeline register slice; refills in the same cycle it drains.
module and_or_stage
    import and_or_pkg::*;
#(
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/and_or_pipe.sv
// Two-stage pipelined AND-OR: out = |(a[i] & b[i]) per lane, plus saturating hit counter.
// Optional out_n port (~out) is enabled by defining AND_OR_OUT_N_EN.
module and_or_pipe
    import and_or_pkg::*;
#(
    parameter int unsigned NUM_PAIRS = 2,
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned COUNT_W   = COUNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       areset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_PAIRS*WIDTH-1:0] a_i,
    input  logic [NUM_PAIRS*WIDTH-1:0] b_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic [COUNT_W-1:0]         hit_cnt
`ifdef AND_OR_OUT_N_EN
    ,
    output logic [WIDTH-1:0]           out_n
`endif
);

    logic [NUM_PAIRS*WIDTH-1:0] s1_in;
    logic [NUM_PAIRS*WIDTH-1:0] s1_data;
    logic                       v1;
    logic                       s2_ready;
    logic [WIDTH-1:0]           s2_in;

    assign s1_in = a_i & b_i;

    // S1 already holds the ANDed pairs, so reducing against all-ones leaves just the OR.
    assign s2_in = WIDTH'(and_or_reduce(and_or_vec_t'(s1_data), '1, NUM_PAIRS, WIDTH));

    and_or_stage #(.DW(NUM_PAIRS * WIDTH)) u_s1 (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (v1),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    and_or_stage #(.DW(WIDTH)) u_s2 (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (v1),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && (out != '0) && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + COUNT_W'(1);
        end
    end

`ifdef AND_OR_OUT_N_EN
    assign out_n = ~out;
`endif

endmodule
